// File: rtl/cdc_pkg.sv
// cdc_pkg
// Shared definitions for the clock-domain-crossing blocks.
//   gray2bin / bin2gray : conversions on a PTR_MAX_W-bit container; callers
//                         zero-extend narrower pointers and cast the result back
//   STAGES_MIN/MAX      : legal synchroniser depths
//   warm_state_e        : warm-up FSM state encoding
package cdc_pkg;

  localparam int PTR_MAX_W  = 32;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } warm_state_e;

  // Zero-extended upper bits decode to zeros, so narrower pointers can use
  // this function unchanged.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// cdc_sync_chain
// Multi-flop synchroniser chain for a bus that is only ever allowed to change
// one bit at a time (e.g. a gray pointer). Depth outside STAGES_MIN..STAGES_MAX
// stops elaboration.
// Ports:
//   clk_i  destination clock
//   rst_i  synchronous active-high reset, clears every stage
//   d_i    asynchronous input bus
//   q_o    synchronised bus (last stage)
module cdc_sync_chain
  import cdc_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("cdc_sync_chain: STAGES must be within 2..4");
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/cdc_sync_ptr.sv
// cdc_sync_ptr
// Destination-domain feeder for async FIFO / credit pointers: synchronises a
// gray pointer, decodes it to binary and reports the per-cycle advance.
// Optional build macro: CDC_SYNC_PTR_GRAY_CHECK_EN enables the sticky
// gray-code violation flag; without it gray_err is tied low.
// Ports:
//   clk          destination clock
//   rst          synchronous active-high reset
//   ptr_gray_in  gray pointer from the source domain (asynchronous)
//   ptr_gray     synchronised gray pointer
//   ptr_bin      registered binary of ptr_gray
//   ptr_delta    advance of ptr_bin since the previous cycle, modulo 2^(ADDRSIZE+1)
//   ptr_changed  one-cycle pulse whenever ptr_delta is nonzero
//   ptr_valid    high once warm-up has finished
//   gray_err     sticky gray-code violation flag
module cdc_sync_ptr
  import cdc_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDRSIZE:0] ptr_gray_in,
  output logic [ADDRSIZE:0] ptr_gray,
  output logic [ADDRSIZE:0] ptr_bin,
  output logic [ADDRSIZE:0] ptr_delta,
  output logic              ptr_changed,
  output logic              ptr_valid,
  output logic              gray_err
);

  localparam int PTR_W = ADDRSIZE + 1;
  localparam int CNT_W = $clog2(STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES + 1);

  if (PTR_W > PTR_MAX_W) begin : g_bad_width
    $error("cdc_sync_ptr: ADDRSIZE+1 exceeds PTR_MAX_W");
  end

  logic [PTR_W-1:0] sync_gray;
  logic [PTR_W-1:0] bin_d;
  logic [PTR_W-1:0] raw_delta;
  logic [PTR_W-1:0] ptr_bin_q, ptr_delta_q, ptr_delta_d;
  logic             ptr_changed_q, ptr_changed_d;
  warm_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cdc_sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (STAGES)
  ) u_chain (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (ptr_gray_in),
    .q_o   (sync_gray)
  );

  // ptr_bin_q is the previous decoded pointer, so the delta is taken against
  // the value being registered this cycle; that keeps ptr_delta aligned with
  // the ptr_bin it describes.
  assign bin_d     = PTR_W'(gray2bin(PTR_MAX_W'(sync_gray)));
  assign raw_delta = bin_d - ptr_bin_q;

  // Warm-up counter and state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Warm-up lasts until the chain and decode stage hold the live pointer, so
  // whatever the source showed at reset release is absorbed without a delta.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_delta_d   = '0;
    ptr_changed_d = 1'b0;
    unique case (state_q)
      WARMUP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        ptr_delta_d   = raw_delta;
        ptr_changed_d = (raw_delta != '0);
      end
      default: state_d = WARMUP;
    endcase
  end

  // Decode, delta and change-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin_q     <= '0;
      ptr_delta_q   <= '0;
      ptr_changed_q <= 1'b0;
    end else begin
      ptr_bin_q     <= bin_d;
      ptr_delta_q   <= ptr_delta_d;
      ptr_changed_q <= ptr_changed_d;
    end
  end

  assign ptr_gray    = sync_gray;
  assign ptr_bin     = ptr_bin_q;
  assign ptr_delta   = ptr_delta_q;
  assign ptr_changed = ptr_changed_q;
  assign ptr_valid   = (state_q == RUN);

`ifdef CDC_SYNC_PTR_GRAY_CHECK_EN
  localparam logic [PTR_W-1:0] HALF = PTR_W'(1) << ADDRSIZE;

  logic gray_err_q, gray_err_d;
  int   hamming;

  // ptr_bin_q re-encoded is last cycle's synchronised gray value. A multi-bit
  // change is fine when it decodes to a forward advance of 1..HALF; anything
  // further is a backward move.
  always_comb begin
    hamming    = $countones(sync_gray ^ PTR_W'(bin2gray(PTR_MAX_W'(ptr_bin_q))));
    gray_err_d = gray_err_q;
    if (state_q == RUN) begin
      if ((hamming > 1 && raw_delta == '0) || raw_delta > HALF) begin
        gray_err_d = 1'b1;
      end
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_err_q <= 1'b0;
    end else begin
      gray_err_q <= gray_err_d;
    end
  end

  assign gray_err = gray_err_q;
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_sync_ptr.sv
// tb_cdc_sync_ptr
// Directed bench for cdc_sync_ptr with ADDRSIZE=4, STAGES=2.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_cdc_sync_ptr;

  localparam int ADDRSIZE = 4;
  localparam int STAGES   = 2;

`ifdef CDC_SYNC_PTR_GRAY_CHECK_EN
  localparam logic ERR_ON_BACKWARD = 1'b1;
`else
  localparam logic ERR_ON_BACKWARD = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [ADDRSIZE:0] ptr_gray_in;
  logic [ADDRSIZE:0] ptr_gray;
  logic [ADDRSIZE:0] ptr_bin;
  logic [ADDRSIZE:0] ptr_delta;
  logic              ptr_changed;
  logic              ptr_valid;
  logic              gray_err;

  int checks;
  int failures;

  cdc_sync_ptr #(
    .ADDRSIZE (ADDRSIZE),
    .STAGES   (STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ptr_gray_in (ptr_gray_in),
    .ptr_gray    (ptr_gray),
    .ptr_bin     (ptr_bin),
    .ptr_delta   (ptr_delta),
    .ptr_changed (ptr_changed),
    .ptr_valid   (ptr_valid),
    .gray_err    (gray_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset cycle with the given input, then enough cycles to leave warm-up.
  task automatic do_reset(input logic [ADDRSIZE:0] g);
    rst = 1'b1;
    ptr_gray_in = g;
    tick();
    rst = 1'b0;
    repeat (STAGES + 3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ptr_gray_in = 5'h07;
    tick();
    checks += 5;
    if (ptr_gray !== 5'd0) begin failures++; $display("[TB] FAIL reset_gray got %0h exp 0", ptr_gray); end
    if (ptr_bin !== 5'd0) begin failures++; $display("[TB] FAIL reset_bin got %0d exp 0", ptr_bin); end
    if (ptr_delta !== 5'd0) begin failures++; $display("[TB] FAIL reset_delta got %0d exp 0", ptr_delta); end
    if (ptr_valid !== 1'b0 || ptr_changed !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_flags got valid=%b changed=%b exp 0 0", ptr_valid, ptr_changed);
    end
    if (gray_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got %b exp 0", gray_err); end
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      checks += 3;
      if (ptr_valid !== (n >= 4)) begin
        failures++; $display("[TB] FAIL warmup_valid cycle %0d got %b exp %b", n, ptr_valid, (n >= 4));
      end
      if (ptr_changed !== 1'b0) begin
        failures++; $display("[TB] FAIL warmup_changed cycle %0d got %b exp 0", n, ptr_changed);
      end
      if (ptr_delta !== 5'd0) begin
        failures++; $display("[TB] FAIL warmup_delta cycle %0d got %0d exp 0", n, ptr_delta);
      end
      if (n == 1) begin
        checks++;
        if (ptr_gray !== 5'd0) begin failures++; $display("[TB] FAIL gray_latency cycle 1 got %0h exp 0", ptr_gray); end
      end
    end
    checks += 2;
    if (ptr_bin !== 5'd5) begin failures++; $display("[TB] FAIL warmup_bin got %0d exp 5", ptr_bin); end
    if (ptr_gray !== 5'h07) begin failures++; $display("[TB] FAIL warmup_gray got %0h exp 07", ptr_gray); end
  endtask

  task automatic test_step();
    do_reset(5'h00);
    ptr_gray_in = 5'h01;
    tick();
    ptr_gray_in = 5'h03;
    tick();
    checks++;
    if (ptr_gray !== 5'h01) begin failures++; $display("[TB] FAIL step_gray1 got %0h exp 01", ptr_gray); end
    tick();
    checks += 4;
    if (ptr_gray !== 5'h03) begin failures++; $display("[TB] FAIL step_gray2 got %0h exp 03", ptr_gray); end
    if (ptr_bin !== 5'd1) begin failures++; $display("[TB] FAIL step_bin1 got %0d exp 1", ptr_bin); end
    if (ptr_delta !== 5'd1) begin failures++; $display("[TB] FAIL step_delta1 got %0d exp 1", ptr_delta); end
    if (ptr_changed !== 1'b1) begin failures++; $display("[TB] FAIL step_changed1 got %b exp 1", ptr_changed); end
    tick();
    checks += 3;
    if (ptr_bin !== 5'd2) begin failures++; $display("[TB] FAIL step_bin2 got %0d exp 2", ptr_bin); end
    if (ptr_delta !== 5'd1) begin failures++; $display("[TB] FAIL step_delta2 got %0d exp 1", ptr_delta); end
    if (ptr_changed !== 1'b1) begin failures++; $display("[TB] FAIL step_changed2 got %b exp 1", ptr_changed); end
    tick();
    checks += 2;
    if (ptr_delta !== 5'd0) begin failures++; $display("[TB] FAIL step_idle_delta got %0d exp 0", ptr_delta); end
    if (ptr_changed !== 1'b0) begin failures++; $display("[TB] FAIL step_idle_changed got %b exp 0", ptr_changed); end
  endtask

  task automatic test_wrap();
    do_reset(5'h10);
    checks++;
    if (ptr_bin !== 5'd31) begin failures++; $display("[TB] FAIL wrap_start got %0d exp 31", ptr_bin); end
    ptr_gray_in = 5'h00;
    repeat (3) tick();
    checks += 4;
    if (ptr_bin !== 5'd0) begin failures++; $display("[TB] FAIL wrap_bin got %0d exp 0", ptr_bin); end
    if (ptr_delta !== 5'd1) begin failures++; $display("[TB] FAIL wrap_delta got %0d exp 1", ptr_delta); end
    if (ptr_changed !== 1'b1) begin failures++; $display("[TB] FAIL wrap_changed got %b exp 1", ptr_changed); end
    if (gray_err !== 1'b0) begin failures++; $display("[TB] FAIL wrap_err got %b exp 0", gray_err); end
  endtask

  task automatic test_skip();
    do_reset(5'h02);
    ptr_gray_in = 5'h05;
    repeat (3) tick();
    checks += 4;
    if (ptr_bin !== 5'd6) begin failures++; $display("[TB] FAIL skip_bin got %0d exp 6", ptr_bin); end
    if (ptr_delta !== 5'd3) begin failures++; $display("[TB] FAIL skip_delta got %0d exp 3", ptr_delta); end
    if (ptr_changed !== 1'b1) begin failures++; $display("[TB] FAIL skip_changed got %b exp 1", ptr_changed); end
    if (gray_err !== 1'b0) begin failures++; $display("[TB] FAIL skip_err got %b exp 0", gray_err); end
    tick();
    checks += 2;
    if (ptr_changed !== 1'b0) begin failures++; $display("[TB] FAIL skip_single_pulse got %b exp 0", ptr_changed); end
    if (gray_err !== 1'b0) begin failures++; $display("[TB] FAIL skip_err_late got %b exp 0", gray_err); end
  endtask

  task automatic test_midstream_reset();
    do_reset(5'h0C);
    ptr_gray_in = 5'h0D;
    repeat (3) tick();
    checks += 2;
    if (ptr_bin !== 5'd9) begin failures++; $display("[TB] FAIL mid_bin got %0d exp 9", ptr_bin); end
    if (ptr_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_valid got %b exp 1", ptr_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (ptr_gray !== 5'd0 || ptr_bin !== 5'd0) begin
      failures++; $display("[TB] FAIL mid_rst_ptr got gray=%0h bin=%0d exp 0 0", ptr_gray, ptr_bin);
    end
    if (ptr_delta !== 5'd0 || ptr_changed !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_rst_delta got delta=%0d changed=%b exp 0 0", ptr_delta, ptr_changed);
    end
    if (ptr_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid got %b exp 0", ptr_valid); end
    for (int n = 1; n <= 6; n++) begin
      tick();
      checks += 2;
      if (ptr_valid !== (n >= 4)) begin
        failures++; $display("[TB] FAIL mid_warm_valid cycle %0d got %b exp %b", n, ptr_valid, (n >= 4));
      end
      if (ptr_changed !== 1'b0 || ptr_delta !== 5'd0) begin
        failures++; $display("[TB] FAIL mid_warm_pulse cycle %0d got changed=%b delta=%0d exp 0 0", n, ptr_changed, ptr_delta);
      end
    end
    checks++;
    if (ptr_bin !== 5'd9) begin failures++; $display("[TB] FAIL mid_resume_bin got %0d exp 9", ptr_bin); end
  endtask

  task automatic test_gray_err();
    do_reset(5'h06);
    checks++;
    if (gray_err !== 1'b0) begin failures++; $display("[TB] FAIL err_before got %b exp 0", gray_err); end
    ptr_gray_in = 5'h01;
    repeat (3) tick();
    checks += 3;
    if (ptr_bin !== 5'd1) begin failures++; $display("[TB] FAIL err_bin got %0d exp 1", ptr_bin); end
    if (ptr_delta !== 5'd29) begin failures++; $display("[TB] FAIL err_delta got %0d exp 29", ptr_delta); end
    if (gray_err !== ERR_ON_BACKWARD) begin
      failures++; $display("[TB] FAIL err_set got %b exp %b", gray_err, ERR_ON_BACKWARD);
    end
    repeat (3) tick();
    checks++;
    if (gray_err !== ERR_ON_BACKWARD) begin
      failures++; $display("[TB] FAIL err_sticky got %b exp %b", gray_err, ERR_ON_BACKWARD);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gray_err !== 1'b0) begin failures++; $display("[TB] FAIL err_clear got %b exp 0", gray_err); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    ptr_gray_in = '0;
    test_reset();
    test_step();
    test_wrap();
    test_skip();
    test_midstream_reset();
    test_gray_err();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
